// File: rtl/intr_vector_arbiter_if.sv
// intr_vector_arbiter_if: bundles the SPR access port, the request/acknowledge
// handshake with the sources and the interrupt presentation to the control unit.
// The slave modport is the arbiter's view; the master modport is the environment.
interface intr_vector_arbiter_if #(
  parameter int NUM_SRC = 8,
  parameter int CODE_W  = 4
) ();
  logic [9:0]         spr_addr;
  logic               spr_wr;
  logic [0:31]        spr_wd;
  logic [0:31]        spr_rd;
  logic [0:31]        MSR;
  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] src_ack;
  logic               intr_valid;
  logic [CODE_W-1:0]  excepCode;
  logic [0:31]        intrEntryAddr;
  logic               ack;
  logic [NUM_SRC-1:0] pending;

  modport slave (
    input  spr_addr, spr_wr, spr_wd, MSR, req, ack,
    output spr_rd, src_ack, intr_valid, excepCode, intrEntryAddr, pending
  );

  modport master (
    output spr_addr, spr_wr, spr_wd, MSR, req, ack,
    input  spr_rd, src_ack, intr_valid, excepCode, intrEntryAddr, pending
  );
endinterface

// File: rtl/intr_vector_arbiter.sv
// intr_vector_arbiter: fixed-priority interrupt controller with IVPR/IVOR SPRs.
// Lowest eligible channel index wins; maskable channels (EXT_MASK) need MSR[EE].
// The winner's code and vectored entry address are latched at arbitration and
// held until the control unit acks, then src_ack pulses for one cycle.
// Optional feature macro INTR_STICKY_EN: when defined, request pulses are
// captured in a sticky pending register; otherwise pending follows req.
module intr_vector_arbiter #(
  parameter int                 NUM_SRC   = 8,
  parameter int                 CODE_W    = 4,
  parameter logic [NUM_SRC-1:0] EXT_MASK  = 8'b0011_0000,
  parameter logic [9:0]         IVOR_BASE = 10'd400,
  parameter logic [9:0]         IVPR_SPRN = 10'd63
) (
  input  logic                 clk,
  input  logic                 rst,
  intr_vector_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPATCH = 2'd1,
    ST_ACK      = 2'd2
  } state_t;

  state_t             state_r, state_n;
  logic [0:15]        ivpr_r;
  logic [16:27]       ivor_r [NUM_SRC];
  logic [CODE_W-1:0]  win_r, win_n;
  logic               intr_valid_r, intr_valid_n;
  logic [CODE_W-1:0]  excep_code_r, excep_code_n;
  logic [0:31]        entry_addr_r, entry_addr_n;
  logic [NUM_SRC-1:0] src_ack_r, src_ack_n;

  logic [NUM_SRC-1:0] pending_s;
  logic [NUM_SRC-1:0] elig_s;
  logic               any_elig_s;
  logic [CODE_W-1:0]  win_idx_s;
  logic [16:27]       win_ivor_s;
  logic [NUM_SRC-1:0] win_onehot_s;
  logic [0:31]        spr_rd_s;
  logic               ee_s;
  logic               unused_s;

  assign ee_s     = bus.MSR[16];
  assign unused_s = ^{bus.MSR[0:15], bus.MSR[17:31], bus.spr_wd[28:31]};

`ifdef INTR_STICKY_EN
  logic [NUM_SRC-1:0] sticky_r;
  logic [NUM_SRC-1:0] clr_s;

  // The winner's pending bit is cleared exactly when DISPATCH is left on ack.
  assign clr_s = (state_r == ST_DISPATCH && bus.ack) ? win_onehot_s : {NUM_SRC{1'b0}};

  // Sticky capture of request pulses; a new pulse beats the clear in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_r <= {NUM_SRC{1'b0}};
    end else begin
      sticky_r <= (sticky_r & ~clr_s) | bus.req;
    end
  end

  assign pending_s = sticky_r;
`else
  assign pending_s = bus.req;
`endif

  assign elig_s = pending_s & (~EXT_MASK | {NUM_SRC{ee_s}});

  // Lowest eligible index wins; scan from the top so the lowest overwrites last.
  always_comb begin
    any_elig_s = 1'b0;
    win_idx_s  = {CODE_W{1'b0}};
    win_ivor_s = 12'h000;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (elig_s[i]) begin
        any_elig_s = 1'b1;
        win_idx_s  = CODE_W'(i);
        win_ivor_s = ivor_r[i];
      end else begin
        any_elig_s = any_elig_s;
      end
    end
  end

  // One-hot form of the latched winner, used for src_ack and the sticky clear.
  always_comb begin
    win_onehot_s = {NUM_SRC{1'b0}};
    for (int i = 0; i < NUM_SRC; i++) begin
      if (win_r == CODE_W'(i)) begin
        win_onehot_s[i] = 1'b1;
      end else begin
        win_onehot_s[i] = 1'b0;
      end
    end
  end

  // FSM next state and next values of the registered outputs.
  always_comb begin
    state_n      = state_r;
    win_n        = win_r;
    intr_valid_n = intr_valid_r;
    excep_code_n = excep_code_r;
    entry_addr_n = entry_addr_r;
    src_ack_n    = {NUM_SRC{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (any_elig_s) begin
          win_n        = win_idx_s;
          intr_valid_n = 1'b1;
          excep_code_n = win_idx_s + CODE_W'(1);
          entry_addr_n = {ivpr_r, win_ivor_s, 4'b0000};
          state_n      = ST_DISPATCH;
        end else begin
          state_n      = ST_IDLE;
        end
      end
      ST_DISPATCH: begin
        if (bus.ack) begin
          intr_valid_n = 1'b0;
          excep_code_n = {CODE_W{1'b0}};
          entry_addr_n = 32'h0000_0000;
          src_ack_n    = win_onehot_s;
          state_n      = ST_ACK;
        end else begin
          state_n      = ST_DISPATCH;
        end
      end
      ST_ACK: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n      = ST_IDLE;
        intr_valid_n = 1'b0;
        excep_code_n = {CODE_W{1'b0}};
        entry_addr_n = 32'h0000_0000;
      end
    endcase
  end

  // FSM state and registered outputs; reset drops any in-flight interrupt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      win_r        <= {CODE_W{1'b0}};
      intr_valid_r <= 1'b0;
      excep_code_r <= {CODE_W{1'b0}};
      entry_addr_r <= 32'h0000_0000;
      src_ack_r    <= {NUM_SRC{1'b0}};
    end else begin
      state_r      <= state_n;
      win_r        <= win_n;
      intr_valid_r <= intr_valid_n;
      excep_code_r <= excep_code_n;
      entry_addr_r <= entry_addr_n;
      src_ack_r    <= src_ack_n;
    end
  end

  // IVPR/IVOR storage; writes to unmapped SPR numbers fall through untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ivpr_r <= 16'h0000;
      for (int i = 0; i < NUM_SRC; i++) begin
        ivor_r[i] <= 12'h000;
      end
    end else if (bus.spr_wr) begin
      if (bus.spr_addr == IVPR_SPRN) begin
        ivpr_r <= bus.spr_wd[0:15];
      end else begin
        ivpr_r <= ivpr_r;
      end
      for (int i = 0; i < NUM_SRC; i++) begin
        if (bus.spr_addr == IVOR_BASE + 10'(i)) begin
          ivor_r[i] <= bus.spr_wd[16:27];
        end else begin
          ivor_r[i] <= ivor_r[i];
        end
      end
    end else begin
      ivpr_r <= ivpr_r;
    end
  end

  // SPR read mux: stored field in position, zeros elsewhere, unmapped reads 0.
  always_comb begin
    spr_rd_s = 32'h0000_0000;
    if (bus.spr_addr == IVPR_SPRN) begin
      spr_rd_s = {ivpr_r, 16'h0000};
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (bus.spr_addr == IVOR_BASE + 10'(i)) begin
          spr_rd_s = {16'h0000, ivor_r[i], 4'b0000};
        end else begin
          spr_rd_s = spr_rd_s;
        end
      end
    end
  end

  assign bus.spr_rd        = spr_rd_s;
  assign bus.src_ack       = src_ack_r;
  assign bus.intr_valid    = intr_valid_r;
  assign bus.excepCode     = excep_code_r;
  assign bus.intrEntryAddr = entry_addr_r;
  assign bus.pending       = pending_s;

endmodule
